// File: rtl/sim_end_monitor.sv
// End-of-test monitor: snoops NUM_CH SRAM write ports for END_CODE@END_ADDR, flags done/timeout,
// counts run cycles and result-window writes. Optional signature via `define SIM_SIGNATURE_EN.
module sim_end_monitor #(
  parameter int                NUM_CH    = 2,
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] END_ADDR  = 14'h3fff,
  parameter logic [31:0]       END_CODE  = 32'hffffffff,
  parameter logic [ADDR_W-1:0] RES_BASE  = 14'h2000,
  parameter int                RES_WORDS = 64,
  parameter int                MAX_CYCLE = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        snoop_ceb,
  input  logic [NUM_CH*4-1:0]      snoop_web,
  input  logic [NUM_CH*ADDR_W-1:0] snoop_a,
  input  logic [NUM_CH*32-1:0]     snoop_di,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     sim_done,
  output logic                     sim_timeout,
  output logic [63:0]              cycle_cnt,
  output logic [15:0]              res_wr_cnt,
  output logic [31:0]              signature,
  output logic [1:0]               fsm_state
);

  // Window bounds carry one extra bit so the upper limit cannot wrap.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, RES_BASE};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(RES_WORDS);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("sim_end_monitor: NUM_CH must be 1..8");
  end
  if (int'(RES_BASE) + RES_WORDS > (1 << ADDR_W)) begin : g_bad_window
    $error("sim_end_monitor: result window exceeds address space");
  end
  if (MAX_CYCLE < 2) begin : g_bad_max_cycle
    $error("sim_end_monitor: MAX_CYCLE must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   ch_done_q, ch_done_d;
  logic [63:0]         cycle_q, cycle_d;
  logic [15:0]         res_q, res_d;
  logic [NUM_CH-1:0]   fw, end_hit, in_win;
  logic [3:0]          n_win;
  logic [16:0]         res_sum;
  logic                all_done;
  logic                run;

  always_comb begin
    fw      = '0;
    end_hit = '0;
    in_win  = '0;
    n_win   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fw[c]      = !snoop_ceb[c] && (snoop_web[c*4 +: 4] == 4'b0000);
      end_hit[c] = fw[c] && (snoop_a[c*ADDR_W +: ADDR_W] == END_ADDR)
                         && (snoop_di[c*32 +: 32] == END_CODE);
      in_win[c]  = fw[c] && ({1'b0, snoop_a[c*ADDR_W +: ADDR_W]} >= WIN_LO)
                         && ({1'b0, snoop_a[c*ADDR_W +: ADDR_W]} <  WIN_HI);
      if (in_win[c]) n_win = n_win + 4'd1;
    end
  end

  assign all_done = &(ch_done_q | end_hit);
  assign run      = (state_q == ST_RUN);
  assign res_sum  = {1'b0, res_q} + 17'(n_win);

  always_comb begin
    state_d   = state_q;
    ch_done_d = ch_done_q;
    cycle_d   = cycle_q;
    res_d     = res_q;
    if (run) begin
      ch_done_d = ch_done_q | end_hit;
      res_d     = res_sum[16] ? 16'hffff : res_sum[15:0];
      // Completion beats timeout on the same edge; the count freezes on either exit.
      if (all_done) begin
        state_d = ST_DONE;
      end else if (cycle_q == 64'(MAX_CYCLE - 1)) begin
        state_d = ST_TIMEOUT;
      end else begin
        cycle_d = cycle_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      ch_done_q <= '0;
      cycle_q   <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      ch_done_q <= ch_done_d;
      cycle_q   <= cycle_d;
      res_q     <= res_d;
    end
  end

`ifdef SIM_SIGNATURE_EN
  logic [31:0] sig_q, sig_d;

  // Channels fold in ascending index order within one cycle.
  always_comb begin
    sig_d = sig_q;
    if (run) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_win[c]) begin
          sig_d = {sig_d[30:0], sig_d[31]} ^ snoop_di[c*32 +: 32]
                ^ 32'(snoop_a[c*ADDR_W +: ADDR_W] - RES_BASE);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  assign signature = 32'h0;
`endif

  assign ch_done     = ch_done_q;
  assign sim_done    = (state_q == ST_DONE);
  assign sim_timeout = (state_q == ST_TIMEOUT);
  assign cycle_cnt   = cycle_q;
  assign res_wr_cnt  = res_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_sim_end_monitor.sv
// Directed bench for sim_end_monitor: a default instance and a MAX_CYCLE=20 instance share stimulus.
module tb_sim_end_monitor;

  localparam int NCH = 2;
  localparam int AW  = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ceb;
  logic [NCH*4-1:0]  web;
  logic [NCH*AW-1:0] adr;
  logic [NCH*32-1:0] dat;

  logic [NCH-1:0] chd [2];
  logic           done[2];
  logic           tout[2];
  logic [63:0]    cyc [2];
  logic [15:0]    resc[2];
  logic [31:0]    sig [2];
  logic [1:0]     st  [2];

  always #5 clk = ~clk;

  sim_end_monitor dut (
    .clk(clk), .rst(rst), .snoop_ceb(ceb), .snoop_web(web), .snoop_a(adr), .snoop_di(dat),
    .ch_done(chd[0]), .sim_done(done[0]), .sim_timeout(tout[0]), .cycle_cnt(cyc[0]),
    .res_wr_cnt(resc[0]), .signature(sig[0]), .fsm_state(st[0])
  );

  sim_end_monitor #(.MAX_CYCLE(20)) dut_to (
    .clk(clk), .rst(rst), .snoop_ceb(ceb), .snoop_web(web), .snoop_a(adr), .snoop_di(dat),
    .ch_done(chd[1]), .sim_done(done[1]), .sim_timeout(tout[1]), .cycle_cnt(cyc[1]),
    .res_wr_cnt(resc[1]), .signature(sig[1]), .fsm_state(st[1])
  );

  localparam int K_CHD = 0, K_DONE = 1, K_TO = 2, K_CYC = 3, K_RES = 4, K_SIG = 5, K_ST = 6;

  typedef struct {
    int    inst;
    int    kind;
    string tag;
  } meta_t;

  logic [63:0] exp_q[$];
  meta_t       meta_q[$];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [63:0] observe(input int inst, input int kind);
    case (kind)
      K_CHD:   return 64'(chd[inst]);
      K_DONE:  return 64'(done[inst]);
      K_TO:    return 64'(tout[inst]);
      K_CYC:   return cyc[inst];
      K_RES:   return 64'(resc[inst]);
      K_SIG:   return 64'(sig[inst]);
      default: return 64'(st[inst]);
    endcase
  endfunction

  task automatic push(input int inst, input int kind, input logic [63:0] v, input string tag);
    meta_t m;
    m.inst = inst; m.kind = kind; m.tag = tag;
    exp_q.push_back(v);
    meta_q.push_back(m);
  endtask

  task automatic push_status(input int inst, input logic [1:0] c, input logic d, input logic t,
                             input logic [63:0] n, input logic [1:0] s, input string tag);
    push(inst, K_CHD,  64'(c), {tag, ".ch_done"});
    push(inst, K_DONE, 64'(d), {tag, ".sim_done"});
    push(inst, K_TO,   64'(t), {tag, ".sim_timeout"});
    push(inst, K_CYC,  n,      {tag, ".cycle_cnt"});
    push(inst, K_ST,   64'(s), {tag, ".fsm_state"});
  endtask

  task automatic sb_drain();
    logic [63:0] e, o;
    meta_t m;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = meta_q.pop_front();
      o = observe(m.inst, m.kind);
      checks++;
      assert (o === e) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", m.tag, o, e);
      end
    end
  endtask

  task automatic idle_inputs();
    ceb = '1; web = '1; adr = '0; dat = '0;
  endtask

  task automatic wr(input int c, input logic [3:0] w, input logic [AW-1:0] a, input logic [31:0] d);
    ceb[c] = 1'b0;
    web[c*4 +: 4] = w;
    adr[c*AW +: AW] = a;
    dat[c*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
    sb_drain();
  endtask

  task automatic run_idle(input int n);
    repeat (n) tick();
  endtask

  // Next posedge after this returns is edge 1.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    for (int i = 0; i < 2; i++) begin
      push_status(i, 2'b00, 1'b0, 1'b0, 64'd0, 2'd0, tag);
      push(i, K_RES, 64'd0, {tag, ".res_wr_cnt"});
      push(i, K_SIG, 64'd0, {tag, ".signature"});
    end
    sb_drain();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [31:0] d,
                                           input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - 14'h2000;
    return {s[30:0], s[31]} ^ d ^ 32'(off);
  endfunction

  logic [31:0] d0, d1, d2, d3, d4, sig_m, sig_exp;

  initial begin
    rst = 1'b1;
    idle_inputs();

    // T1: ch0 ends on edge 10, ch1 on edge 25.
    do_reset("t1_reset");
    run_idle(9);
    wr(0, 4'b0000, 14'h3fff, 32'hffffffff);
    push_status(0, 2'b01, 1'b0, 1'b0, 64'd10, 2'd0, "t1_e10");
    tick();
    run_idle(14);
    wr(1, 4'b0000, 14'h3fff, 32'hffffffff);
    push_status(0, 2'b11, 1'b1, 1'b0, 64'd24, 2'd1, "t1_e25");
    tick();
    wr(0, 4'b0000, 14'h2000, 32'h1234);
    wr(1, 4'b0000, 14'h3fff, 32'h0);
    push_status(0, 2'b11, 1'b1, 1'b0, 64'd24, 2'd1, "t1_frozen");
    push(0, K_RES, 64'd0, "t1_frozen.res_wr_cnt");
    tick();
    run_idle(3);
    push(0, K_CYC, 64'd24, "t1_late.cycle_cnt");
    tick();

    // T2: both channels end on edge 7.
    do_reset("t2_reset");
    run_idle(6);
    wr(0, 4'b0000, 14'h3fff, 32'hffffffff);
    wr(1, 4'b0000, 14'h3fff, 32'hffffffff);
    push_status(0, 2'b11, 1'b1, 1'b0, 64'd6, 2'd1, "t2_e7");
    tick();

    // T3: near-miss writes never set a flag; a wrong value does not clear one.
    do_reset("t3_reset");
    wr(0, 4'b1110, 14'h3fff, 32'hffffffff);
    push_status(0, 2'b00, 1'b0, 1'b0, 64'd1, 2'd0, "t3_partial");
    tick();
    wr(0, 4'b0000, 14'h3fff, 32'h0);
    push_status(0, 2'b00, 1'b0, 1'b0, 64'd2, 2'd0, "t3_badval");
    tick();
    wr(0, 4'b0000, 14'h3ffe, 32'hffffffff);
    wr(1, 4'b0000, 14'h3fff, 32'hfffffffe);
    push_status(0, 2'b00, 1'b0, 1'b0, 64'd3, 2'd0, "t3_badaddr");
    tick();
    wr(1, 4'b0000, 14'h3fff, 32'hffffffff);
    push_status(0, 2'b10, 1'b0, 1'b0, 64'd4, 2'd0, "t3_ch1");
    tick();
    wr(1, 4'b0000, 14'h3fff, 32'h5a5a5a5a);
    wr(0, 4'b0001, 14'h3fff, 32'hffffffff);
    push_status(0, 2'b10, 1'b0, 1'b0, 64'd5, 2'd0, "t3_noclear");
    tick();

    // T4: timeout instance with no end writes, then the last hit on edge 20.
    do_reset("t4_reset");
    run_idle(18);
    push_status(1, 2'b00, 1'b0, 1'b0, 64'd19, 2'd0, "t4_e19");
    tick();
    push_status(1, 2'b00, 1'b0, 1'b1, 64'd19, 2'd2, "t4_e20");
    tick();
    wr(0, 4'b0000, 14'h3fff, 32'hffffffff);
    wr(1, 4'b0000, 14'h3fff, 32'hffffffff);
    push_status(1, 2'b00, 1'b0, 1'b1, 64'd19, 2'd2, "t4_terminal");
    tick();
    do_reset("t4v_reset");
    run_idle(4);
    wr(0, 4'b0000, 14'h3fff, 32'hffffffff);
    tick();
    run_idle(14);
    wr(1, 4'b0000, 14'h3fff, 32'hffffffff);
    push_status(1, 2'b11, 1'b1, 1'b0, 64'd19, 2'd1, "t4v_e20");
    tick();

    // T5: result-window counting and signature.
    do_reset("t5_reset");
    d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom; d4 = $urandom;
    sig_m = '0;
    wr(0, 4'b0000, 14'h2000, d0);
    wr(1, 4'b0000, 14'h203f, d1);
    sig_m = sig_step(sig_m, d0, 14'h2000);
    sig_m = sig_step(sig_m, d1, 14'h203f);
    push(0, K_RES, 64'd2, "t5_e1.res_wr_cnt");
    tick();
    wr(0, 4'b0000, 14'h2005, d2);
    wr(1, 4'b0000, 14'h2040, $urandom);
    sig_m = sig_step(sig_m, d2, 14'h2005);
    push(0, K_RES, 64'd3, "t5_e2.res_wr_cnt");
    tick();
    wr(0, 4'b0011, 14'h2001, $urandom);
    wr(1, 4'b0000, 14'h2010, d3);
    sig_m = sig_step(sig_m, d3, 14'h2010);
    tick();
    wr(0, 4'b0000, 14'h201f, d4);
    wr(1, 4'b0000, 14'h1fff, $urandom);
    sig_m = sig_step(sig_m, d4, 14'h201f);
`ifdef SIM_SIGNATURE_EN
    sig_exp = sig_m;
`else
    sig_exp = 32'h0;
`endif
    push(0, K_RES, 64'd5, "t5_e4.res_wr_cnt");
    push(0, K_SIG, 64'(sig_exp), "t5_e4.signature");
    tick();
    push(0, K_RES, 64'd5, "t5_idle.res_wr_cnt");
    push(0, K_SIG, 64'(sig_exp), "t5_idle.signature");
    tick();

    // T6: asynchronous reset mid-run clears everything before the next edge.
    do_reset("t6_reset");
    run_idle(2);
    wr(0, 4'b0000, 14'h3fff, 32'hffffffff);
    push_status(0, 2'b01, 1'b0, 1'b0, 64'd3, 2'd0, "t6_e3");
    tick();
    #1;
    rst = 1'b1;
    #1;
    push_status(0, 2'b00, 1'b0, 1'b0, 64'd0, 2'd0, "t6_async");
    push(0, K_RES, 64'd0, "t6_async.res_wr_cnt");
    sb_drain();
    @(negedge clk);
    rst = 1'b0;
    push_status(0, 2'b00, 1'b0, 1'b0, 64'd1, 2'd0, "t6_restart");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
